// File: rtl/pixel_ctrl.sv
// Pixel-array sequencer: erase/expose/convert/read phases, then a four-pixel
// valid/ready stream from a capture buffer, one frame per START or back-to-back.
module pixel_ctrl #(
  parameter int unsigned C_ERASE   = 5,
  parameter int unsigned C_EXPOSE  = 255,
  parameter int unsigned C_CONVERT = 255,
  parameter int unsigned C_READ    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       START,
  input  logic       CONTINUOUS,
  output logic       ERASE,
  output logic       EXPOSE,
  output logic       CONVERT,
  output logic       READ1,
  output logic       READ2,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [7:0] DATA3,
  input  logic [7:0] DATA4,
  output logic [7:0] PIX_DATA,
  output logic [1:0] PIX_INDEX,
  output logic       PIX_VALID,
  input  logic       PIX_READY,
  output logic       FRAME_DONE,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ1, S_READ2, S_STREAM
  } state_t;

  // Counter holds "cycles remaining after this one", so a phase of N loads N-1.
  localparam logic [7:0] L_ERASE   = 8'(C_ERASE - 1);
  localparam logic [7:0] L_EXPOSE  = 8'(C_EXPOSE - 1);
  localparam logic [7:0] L_CONVERT = 8'(C_CONVERT - 1);
  localparam logic [7:0] L_READ    = 8'(C_READ - 1);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_load;
  logic [1:0] r_k;
  logic [7:0] r_buf [4];
  logic [7:0] r_pix_data;
  logic       r_erase, r_expose, r_convert, r_read1, r_read2;
  logic       r_pix_valid, r_busy;
  logic       w_phase_last, w_accept, w_last_pix;

  assign w_phase_last = (r_cnt == 8'd0);
  assign w_accept     = r_pix_valid & PIX_READY;
  assign w_last_pix   = w_accept & (r_k == 2'd3);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (START)        w_next = S_ERASE;
      S_ERASE:   if (w_phase_last) w_next = S_EXPOSE;
      S_EXPOSE:  if (w_phase_last) w_next = S_CONVERT;
      S_CONVERT: if (w_phase_last) w_next = S_READ1;
      S_READ1:   if (w_phase_last) w_next = S_READ2;
      S_READ2:   if (w_phase_last) w_next = S_STREAM;
      S_STREAM:  if (w_last_pix)   w_next = CONTINUOUS ? S_ERASE : S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_load = 8'd0;
    case (w_next)
      S_ERASE:          w_cnt_load = L_ERASE;
      S_EXPOSE:         w_cnt_load = L_EXPOSE;
      S_CONVERT:        w_cnt_load = L_CONVERT;
      S_READ1, S_READ2: w_cnt_load = L_READ;
      default:          w_cnt_load = 8'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_k         <= 2'd0;
      r_pix_data  <= 8'd0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_erase     <= 1'b0;
      r_expose    <= 1'b0;
      r_convert   <= 1'b0;
      r_read1     <= 1'b0;
      r_read2     <= 1'b0;
    end else begin
      r_state <= w_next;
      // No state loops onto itself, so a state change is exactly a state entry.
      if (w_next != r_state)  r_cnt <= w_cnt_load;
      else if (!w_phase_last) r_cnt <= r_cnt - 8'd1;

      // Strobes decode the next state so they are flops aligned with r_state.
      r_erase     <= (w_next == S_ERASE);
      r_expose    <= (w_next == S_EXPOSE);
      r_convert   <= (w_next == S_CONVERT);
      r_read1     <= (w_next == S_READ1);
      r_read2     <= (w_next == S_READ2);
      r_busy      <= (w_next != S_IDLE);
      r_pix_valid <= (w_next == S_STREAM);

      if (w_next != S_STREAM) begin
        r_k        <= 2'd0;
        r_pix_data <= 8'd0;
      end else if (r_state != S_STREAM) begin
        r_pix_data <= r_buf[0];
      end else if (w_accept) begin
        r_k        <= r_k + 2'd1;
        r_pix_data <= r_buf[r_k + 2'd1];
      end
    end
  end

  // NOTE: the capture buffer has no reset; its contents are only observed after a full read sequence.
  always_ff @(posedge clk) begin
    if (!reset && w_phase_last) begin
      if (r_state == S_READ1) begin
        r_buf[0] <= DATA1;
        r_buf[2] <= DATA3;
      end
      if (r_state == S_READ2) begin
        r_buf[1] <= DATA2;
        r_buf[3] <= DATA4;
      end
    end
  end

  assign ERASE     = r_erase;
  assign EXPOSE    = r_expose;
  assign CONVERT   = r_convert;
  assign READ1     = r_read1;
  assign READ2     = r_read2;
  assign BUSY      = r_busy;
  assign PIX_VALID = r_pix_valid;
  assign PIX_DATA  = r_pix_data;
  assign PIX_INDEX = r_k;
  // The completion pulse marks the accepting handshake itself, so it is qualified by PIX_READY.
  assign FRAME_DONE = w_last_pix;

endmodule
